uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 25000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, serial bit rate in baud.
REQ-003 clk  input  1  system clock; the block uses one clock and all state is clocked on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 rx  input  1  UART RX line, asynchronous to clk, idle high.
REQ-006 rx_read  input  1  one-cycle pulse from the register interface: consume the held byte and clear the sticky flags.
REQ-007 rx_data  output  8  last accepted byte, LSB received first.
REQ-008 rx_ready  output  1  high while rx_data holds an unread byte (maps to status bit 1).
REQ-009 frame_err  output  1  sticky: a stop bit was sampled low.
REQ-010 overrun  output  1  sticky: a byte completed while rx_ready=1 and rx_read=0.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before any use, initialised high.
REQ-012 Oversample tick: one-cycle pulse every DIV = CLK_FREQ/(BAUD_RATE*16) clocks, with integer truncation and minimum 1; tick counter runs continuously.
REQ-013 FSM states: IDLE, START, DATA, STOP; reset state is IDLE.
REQ-014 IDLE: synchronized rx high-to-low edge -> START; clear the 4-bit tick phase counter.
REQ-015 START: at phase 7 (mid start bit), sampled 1 -> IDLE (false start, no flag); sampled 0 -> DATA, bit index 0, phase cleared.
REQ-016 DATA: sample at each phase-15 wrap (mid bit); shift into shift register LSB first; after bit index 7 -> STOP.
REQ-017 STOP: sample mid stop bit, then return to IDLE immediately, without waiting for the end of the bit, so back-to-back frames are accepted.
REQ-018 Stop sampled 1 with rx_ready=0, or with rx_read=1 that same cycle: rx_data <= shift register and rx_ready=1 on the next clock.
REQ-019 Stop sampled 1 with rx_ready=1 and rx_read=0: new byte discarded, rx_data unchanged, overrun <= 1.
REQ-020 Stop sampled 0: byte discarded and frame_err <= 1; a line held low afterwards SHALL NOT retrigger until it returns high, since the edge detector needs a prior high.
REQ-021 rx_read alone: rx_ready, frame_err and overrun <= 0 next cycle; rx_data held; rx_read while rx_ready=0 is harmless.
REQ-022 If rx_read and a flag-set event occur in the same cycle, the set wins for that flag.
REQ-023 Latency: rx_ready rises exactly one clk after the stop-bit sample cycle.

Reset
REQ-024 rst_n low, at any time including mid-frame, SHALL force IDLE, rx_data=8'h00, rx_ready=0, frame_err=0, overrun=0, all counters 0 and synchronizer flops 1.
REQ-025 After rst_n deasserts, the first valid frame SHALL be received normally.

Configuration
REQ-026 Macro UART_RX_MAJORITY_EN defined: each bit value (start, data, stop) is the 2-of-3 majority of samples at phases 7, 8 and 9, decided at phase 9.
REQ-027 Macro undefined: single sample at phase 7; the phase numbers in REQ-015/016 apply exactly; latency per REQ-023 measured from the deciding sample.

Structure
REQ-028 Shared package uart_pkg SHALL hold the FSM state encodings and OVERSAMPLE=16; uart_tx SHALL reuse OVERSAMPLE where applicable.
REQ-029 Sub-module uart_baud_gen (parameters CLK_FREQ, BAUD_RATE; output tick16) SHALL generate the oversample tick; the rest of the logic stays in uart_rx.
REQ-030 Resource guide: 120-400 lines of RTL, no memories, no FIFO.

Verification (bench: CLK_FREQ=1600000, BAUD_RATE=10000 -> DIV=10, 160 clk/bit)
REQ-031 Frame 0x55 with a valid stop bit -> rx_data=8'h55, rx_ready=1 one clk after the stop sample, both flags 0; rx_read -> rx_ready=0.
REQ-032 Frames 0xA3 then 0x0F back-to-back, with rx_read pulsed between them -> both bytes delivered in order, no flags.
REQ-033 Frame 0x12 unread, then frame 0x34 -> rx_data stays 8'h12, overrun=1; rx_read clears rx_ready and overrun.
REQ-034 Frame 0xFF with stop bit driven 0 -> rx_ready=0, frame_err=1; then line high and frame 0x81 -> rx_data=8'h81.
REQ-035 rx low pulse of 40 clks -> false start, FSM back in IDLE, nothing flagged; with UART_RX_MAJORITY_EN, a 1-clk glitch at phase 8 of a data bit is rejected.
REQ-036 rst_n asserted mid-DATA -> all outputs at reset values immediately; the next frame 0xC6 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling ratio, receiver FSM encoding,
// sample-phase constants and small helper functions.
package uart_pkg;

  // Oversample ticks per bit period, shared by uart_rx and uart_tx.
  localparam int OVERSAMPLE = 16;

  // Receiver states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // Tick phases within a bit. Single-sample mode re-aligns the phase counter
  // to mid start bit, so later bits are sampled on the phase-15 wrap.
  localparam logic [3:0] PHASE_MID  = 4'd7;
  localparam logic [3:0] PHASE_MID2 = 4'd8;
  localparam logic [3:0] PHASE_VOTE = 4'd9;
  localparam logic [3:0] PHASE_LAST = 4'd15;

  // Clocks per oversample tick, truncated, never below 1.
  function automatic int calc_div(input int clk_freq, input int baud_rate);
    int div;
    div = clk_freq / (baud_rate * OVERSAMPLE);
    return (div < 1) ? 1 : div;
  endfunction

  // 2-of-3 majority vote.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator: tick16 pulses for one clock every
// calc_div(CLK_FREQ, BAUD_RATE) clocks.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 25000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick16
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick16 = (cnt_q == DIV_LAST);

  // Next count: wrap after DIV_LAST, otherwise increment.
  always_comb begin
    if (cnt_q == DIV_LAST) cnt_d = '0;
    else                   cnt_d = cnt_q + 1'b1;
  end

  // Tick counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, 16x oversampling, with sticky frame/overrun flags.
// Optional build macro UART_RX_MAJORITY_EN: each bit is the 2-of-3 majority
// of samples at phases 7, 8 and 9 (decided at phase 9); when undefined a
// single sample at phase 7 of the start bit aligns the later samples.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 25000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rx_read,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  logic tick16;

  uart_baud_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_baud_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick16 (tick16)
  );

  // Synchronizer, edge history and receiver state.
  logic [1:0] sync_q,    sync_d;
  logic       rx_prev_q, rx_prev_d;
  rx_state_e  state_q,   state_d;
  logic [3:0] phase_q,   phase_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q,   shift_d;
  logic [7:0] data_q,    data_d;
  logic       ready_q,   ready_d;
  logic       fe_q,      fe_d;
  logic       ov_q,      ov_d;

  logic rx_s;
  logic rx_fall;
  logic start_decide;
  logic bit_decide;
  logic bit_val;

  assign rx_s    = sync_q[1];
  assign rx_fall = rx_prev_q & ~rx_s;

`ifdef UART_RX_MAJORITY_EN
  // Samples taken at phases 7 and 8; the phase-9 sample completes the vote.
  logic [1:0] vote_q, vote_d;

  assign start_decide = tick16 && (phase_q == PHASE_VOTE);
  assign bit_decide   = start_decide;
  assign bit_val      = majority3(vote_q[0], vote_q[1], rx_s);

  // Capture the first two votes of each bit.
  always_comb begin
    vote_d = vote_q;
    if (tick16 && (phase_q == PHASE_MID))  vote_d[0] = rx_s;
    if (tick16 && (phase_q == PHASE_MID2)) vote_d[1] = rx_s;
  end

  // Vote sample register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vote_q <= 2'b11;
    else        vote_q <= vote_d;
  end
`else
  assign start_decide = tick16 && (phase_q == PHASE_MID);
  assign bit_decide   = tick16 && (phase_q == PHASE_LAST);
  assign bit_val      = rx_s;
`endif

  // Next-state logic for synchronizer, FSM, shifter and output registers.
  always_comb begin
    // NOTE: every signal gets a default here first, so no path through the
    // case/if tree can leave one unassigned and infer a latch.
    sync_d    = {sync_q[0], rx};
    rx_prev_d = rx_s;
    state_d   = state_q;
    phase_d   = phase_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ready_d   = ready_q;
    fe_d      = fe_q;
    ov_d      = ov_q;

    if (tick16 && (state_q != ST_IDLE)) phase_d = phase_q + 1'b1;

    // A read clears the flags; a set in the same cycle below takes priority.
    if (rx_read) begin
      ready_d = 1'b0;
      fe_d    = 1'b0;
      ov_d    = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_fall) begin
          state_d = ST_START;
          phase_d = '0;
        end
      end
      ST_START: begin
        if (start_decide) begin
          if (bit_val) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
`ifndef UART_RX_MAJORITY_EN
            phase_d   = '0;
`endif
          end
        end
      end
      ST_DATA: begin
        if (bit_decide) begin
          shift_d = {bit_val, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
          else                   bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      ST_STOP: begin
        // Leave at mid stop bit so a following start edge is not missed.
        if (bit_decide) begin
          state_d = ST_IDLE;
          if (bit_val) begin
            if (!ready_q || rx_read) begin
              data_d  = shift_q;
              ready_d = 1'b1;
            end else begin
              ov_d = 1'b1;
            end
          end else begin
            fe_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Receiver FSM and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: only control/data registers here, no storage arrays, so all of
    // them can take an async reset value; the synchronizer resets to idle-high.
    if (!rst_n) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      rx_prev_q <= rx_prev_d;
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_ready  = ready_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;

endmodule
